bus_stream_ser: RTL and testbench



---
 rtl/bus_stream_ser.sv | 90 +++++++++
 tb/tb_bus_stream_ser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_stream_ser.sv
// Serializes one address/data bus transfer into a fixed-length byte frame on a
// valid/ready stream. Single entry; back-to-back frames reload on the last byte.
module bus_stream_ser #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 8,
    parameter int BE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bsi_vld,
    input  logic [AW-1:0] bsi_adr,
    input  logic [DW-1:0] bsi_dat,
    output logic          bsi_rdy,
    output logic          sto_vld,
    output logic [BW-1:0] sto_bus,
    input  logic          sto_rdy
);

    localparam int SW = AW + DW;
    localparam int N  = SW / BW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sr, sr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last;
    logic          bsi_trn;
    logic          sto_trn;

    assign last    = (cnt == CW'(N - 1));
    assign sto_bus = (BE != 0) ? sr[SW-1 -: BW] : sr[BW-1:0];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        sto_vld   = 1'b0;
        bsi_rdy   = 1'b0;

        case (state)
            IDLE: bsi_rdy = 1'b1;
            SEND: begin
                sto_vld = 1'b1;
                bsi_rdy = last & sto_rdy;
            end
            default: ;
        endcase

        // Ready is held low for as long as reset is asserted.
        if (rst) bsi_rdy = 1'b0;

        bsi_trn = bsi_vld & bsi_rdy;
        sto_trn = sto_vld & sto_rdy;

        // A bus transfer in SEND can only happen on the last byte, so it doubles as reload.
        if (bsi_trn) begin
            sr_nxt    = {bsi_adr, bsi_dat};
            cnt_nxt   = '0;
            state_nxt = SEND;
        end else if (sto_trn) begin
            if (last) begin
                state_nxt = IDLE;
            end else begin
                sr_nxt  = (BE != 0) ? (sr << BW) : (sr >> BW);
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_stream_ser.sv
// Self-checking bench for bus_stream_ser: MSB-first and LSB-first instances
// share bus/stream inputs; table-driven vectors plus directed corner sequences.
module tb_bus_stream_ser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bsi_vld = 1'b0;
    logic [31:0] bsi_adr = '0;
    logic [31:0] bsi_dat = '0;
    logic        sto_rdy = 1'b0;

    logic        bsi_rdy1, sto_vld1;
    logic [7:0]  sto_bus1;
    logic        bsi_rdy0, sto_vld0;
    logic [7:0]  sto_bus0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_stream_ser #(.AW(32), .DW(32), .BW(8), .BE(1)) dut (
        .clk(clk), .rst(rst),
        .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat), .bsi_rdy(bsi_rdy1),
        .sto_vld(sto_vld1), .sto_bus(sto_bus1), .sto_rdy(sto_rdy)
    );

    bus_stream_ser #(.AW(32), .DW(32), .BW(8), .BE(0)) dut_le (
        .clk(clk), .rst(rst),
        .bsi_vld(bsi_vld), .bsi_adr(bsi_adr), .bsi_dat(bsi_dat), .bsi_rdy(bsi_rdy0),
        .sto_vld(sto_vld0), .sto_bus(sto_bus0), .sto_rdy(sto_rdy)
    );

    typedef struct {
        logic        vld;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        rdy;
        logic        exp_vld;
        logic [7:0]  exp_bus;
        logic        exp_brdy;
        logic        chk_bus;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
        return v[63-8*i -: 8];
    endfunction

    task automatic add_vec(input logic vld, input logic [31:0] adr, input logic [31:0] dat,
                           input logic rdy, input logic exp_vld, input logic [7:0] exp_bus,
                           input logic exp_brdy, input logic chk_bus);
        vec_t v;
        v.vld = vld; v.adr = adr; v.dat = dat; v.rdy = rdy;
        v.exp_vld = exp_vld; v.exp_bus = exp_bus; v.exp_brdy = exp_brdy; v.chk_bus = chk_bus;
        vecs.push_back(v);
    endtask

    // Eight byte cycles of one MSB-first frame; the bus inputs presented during the
    // frame are nvld/nadr/ndat, and byte stall_idx is stalled for stall_n cycles first.
    task automatic add_frame(input logic [63:0] bytes, input logic nvld, input logic [31:0] nadr,
                             input logic [31:0] ndat, input int stall_idx, input int stall_n);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_idx)
                for (int s = 0; s < stall_n; s++)
                    add_vec(nvld, nadr, ndat, 1'b0, 1'b1, byte_of(bytes, i), 1'b0, 1'b1);
            add_vec(nvld, nadr, ndat, 1'b1, 1'b1, byte_of(bytes, i), (i == 7), 1'b1);
        end
    endtask

    // Load one transfer from idle and check both instances' full frames.
    task automatic send_and_check(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [63:0] exp1, input logic [63:0] exp0);
        bsi_vld = 1'b1; bsi_adr = adr; bsi_dat = dat; sto_rdy = 1'b1;
        @(negedge clk);
        check($sformatf("%s_load_rdy", tag), bsi_rdy1, 1'b1);
        @(posedge clk); #1;
        bsi_vld = 1'b0; bsi_adr = '1; bsi_dat = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("%s_vld_b%0d", tag, i), sto_vld1, 1'b1);
            check($sformatf("%s_be1_b%0d", tag, i), sto_bus1, byte_of(exp1, i));
            check($sformatf("%s_be0_b%0d", tag, i), sto_bus0, byte_of(exp0, i));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("%s_end_vld", tag), {sto_vld1, sto_vld0}, 2'b00);
        @(posedge clk); #1;
    endtask

    logic [31:0] mem_in  [10];
    logic [31:0] mem_out [10];

    initial begin
        // Reset state
        #12;
        check("rst_sto_vld", {sto_vld1, sto_vld0}, 2'b00);
        check("rst_sto_bus", {sto_bus1, sto_bus0}, 16'h0000);
        check("rst_bsi_rdy", {bsi_rdy1, bsi_rdy0}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_bsi_rdy", {bsi_rdy1, bsi_rdy0}, 2'b11);
        @(posedge clk); #1;

        // Single frame, then the same frame with a 3-cycle stall on byte 2,
        // then two back-to-back frames with bsi_vld held high.
        add_vec(1'b1, 32'h00000003, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add_frame(64'h00000003_DEADBEEF, 1'b0, 32'h0, 32'h0, -1, 0);
        add_vec(1'b1, 32'h00000003, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add_frame(64'h00000003_DEADBEEF, 1'b0, 32'h0, 32'h0, 2, 3);
        add_vec(1'b1, 32'h00000000, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        add_frame(64'h00000000_11223344, 1'b1, 32'h00000001, 32'h55667788, -1, 0);
        add_frame(64'h00000001_55667788, 1'b0, 32'h0, 32'h0, -1, 0);
        add_vec(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            bsi_vld = vecs[i].vld; bsi_adr = vecs[i].adr; bsi_dat = vecs[i].dat;
            sto_rdy = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_sto_vld", i), sto_vld1, vecs[i].exp_vld);
            check($sformatf("vec%0d_bsi_rdy", i), bsi_rdy1, vecs[i].exp_brdy);
            if (vecs[i].chk_bus)
                check($sformatf("vec%0d_sto_bus", i), sto_bus1, vecs[i].exp_bus);
            @(posedge clk); #1;
        end

        // LSB-first ordering on the BE=0 instance
        send_and_check("le", 32'h0A0B0C0D, 32'h01020304,
                       64'h0A0B0C0D_01020304, 64'h04030201_0D0C0B0A);

        // Reset after byte 3 of a frame abandons it
        bsi_vld = 1'b1; bsi_adr = 32'h12345678; bsi_dat = 32'h9ABCDEF0; sto_rdy = 1'b1;
        @(posedge clk); #1;
        bsi_vld = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_pre_rst_vld", sto_vld1, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_sto_vld", {sto_vld1, sto_vld0}, 2'b00);
        check("mid_rst_bsi_rdy", {bsi_rdy1, bsi_rdy0}, 2'b00);
        check("mid_rst_sto_bus", {sto_bus1, sto_bus0}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rel_bsi_rdy", {bsi_rdy1, bsi_rdy0}, 2'b11);
        check("mid_rel_sto_vld", {sto_vld1, sto_vld0}, 2'b00);
        @(posedge clk); #1;
        send_and_check("rst", 32'h00000005, 32'h00000000,
                       64'h00000005_00000000, 64'h00000000_05000000);

        // Loopback: random stalls, frames reassembled into an output memory
        for (int i = 0; i < 10; i++) begin
            mem_in[i]  = $urandom;
            mem_out[i] = ~mem_in[i];
        end
        begin
            int          idx = 0;
            int          nrx = 0;
            int          rxn = 0;
            int          cyc = 0;
            logic        btrn;
            logic [63:0] rxw = '0;
            while (nrx < 10 && cyc < 3000) begin
                bsi_vld = (idx < 10);
                bsi_adr = 32'(idx);
                bsi_dat = (idx < 10) ? mem_in[idx] : 32'h0;
                sto_rdy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                btrn = bsi_vld & bsi_rdy1;
                if (sto_vld1 && sto_rdy) begin
                    rxw = {rxw[55:0], sto_bus1};
                    rxn++;
                    if (rxn == 8) begin
                        if (rxw[63:32] < 10) mem_out[rxw[63:32]] = rxw[31:0];
                        nrx++;
                        rxn = 0;
                    end
                end
                @(posedge clk); #1;
                if (btrn) idx++;
                cyc++;
            end
            check("loop_frames_received", 64'(nrx), 64'd10);
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("loop_mem%0d", i), mem_out[i], mem_in[i]);

        bsi_vld = 1'b0; sto_rdy = 1'b1;
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
